// File: rtl/issue_scheduler.sv
// Issue controller between instruction memory and decode: blocks RAW/flag hazards
// with bubbles, holds across control flow until execute resolves it, drops wrong-path fetches.
module issue_scheduler #(
  parameter int HAZARD_DEPTH = 2,
  parameter int FLUSH_SLOTS  = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             br_resolved,
  input  logic             br_taken,
  output logic             stall,
  output logic [31:0]      issue_instr,
  output logic             issue_valid,
  output logic [CNT_W-1:0] stall_count,
  output logic [1:0]       dbg_state
);

  // Fetch handshake: instr_valid marks a fetched word; stall=1 in that cycle means the
  // word was not consumed and fetch re-presents it next cycle. stall=0 consumes it.
  typedef enum logic [1:0] {S_RUN = 2'd0, S_BR_WAIT = 2'd1, S_FLUSH = 2'd2} state_t;

  typedef struct packed {
    logic       valid;
    logic       writes;
    logic [5:0] rd;
    logic       sets_flags;
  } sb_entry_t;

  state_t    state_q, state_d;
  logic [1:0] flush_cnt;
  sb_entry_t sb [HAZARD_DEPTH];

  logic [3:0] op;
  logic [5:0] rd, rs, rt;
  logic reads_rs, reads_rt, reads_flags, writes_rd, sets_flags, is_ctl;
  logic hazard, run_eval, issue_now, cnt_inc, load_flush;

  assign op = instr[31:28];
  assign rd = instr[27:22];
  assign rs = instr[21:16];
  assign rt = instr[15:10];
  assign dbg_state = state_q;

  always_comb begin
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    reads_flags = 1'b0;
    writes_rd   = 1'b0;
    sets_flags  = 1'b0;
    is_ctl      = 1'b0;
    case (op)
      4'h4, 4'h7: begin reads_rs = 1'b1; reads_rt = 1'b1; writes_rd = 1'b1; sets_flags = 1'b1; end
      4'h5, 4'h6: begin reads_rs = 1'b1; writes_rd = 1'b1; sets_flags = 1'b1; end
      4'hE:       begin reads_rs = 1'b1; writes_rd = 1'b1; end
      4'hF:       writes_rd = 1'b1;
      4'h3:       begin reads_rs = 1'b1; reads_rt = 1'b1; end
      4'hA:       begin reads_rs = 1'b1; is_ctl = 1'b1; end
      4'h9, 4'hB: begin reads_rs = 1'b1; reads_flags = 1'b1; is_ctl = 1'b1; end
      default:    ;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZARD_DEPTH; i++) begin
      if (sb[i].valid) begin
        if (sb[i].writes && ((reads_rs && sb[i].rd == rs) || (reads_rt && sb[i].rd == rt)))
          hazard = 1'b1;
        if (reads_flags && sb[i].sets_flags)
          hazard = 1'b1;
      end
    end
  end

  // A not-taken resolution re-evaluates the held fall-through word in the same cycle.
  assign run_eval = (state_q == S_RUN) ||
                    (state_q == S_BR_WAIT && br_resolved && !br_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN, S_BR_WAIT: begin
        if (run_eval)        state_d = (issue_now && is_ctl) ? S_BR_WAIT : S_RUN;
        else if (load_flush) state_d = S_FLUSH;
      end
      S_FLUSH: if (flush_cnt <= 2'd1) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    issue_now  = 1'b0;
    cnt_inc    = 1'b0;
    load_flush = 1'b0;
    if (run_eval) begin
      if (instr_valid && hazard) begin
        stall   = 1'b1;
        cnt_inc = 1'b1;
      end else if (instr_valid) begin
        issue_now = 1'b1;
      end
    end else if (state_q == S_BR_WAIT) begin
      if (br_resolved && br_taken) load_flush = 1'b1;
      else                         stall      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt <= 2'd0;
    end else if (load_flush) begin
      flush_cnt <= 2'(FLUSH_SLOTS);
    end else if (state_q == S_FLUSH && flush_cnt != 2'd0) begin
      flush_cnt <= flush_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HAZARD_DEPTH; i++) sb[i] <= '0;
    end else begin
      sb[0] <= issue_now ? {1'b1, writes_rd, rd, sets_flags} : '0;
      for (int i = 1; i < HAZARD_DEPTH; i++) sb[i] <= sb[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_instr <= 32'h0;
      issue_valid <= 1'b0;
      stall_count <= '0;
    end else begin
      issue_instr <= issue_now ? instr : 32'h0;
      issue_valid <= issue_now;
      if (cnt_inc && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Bench for issue_scheduler: directed vector table, reset-mid-stall sequence and
// random traffic against a cycle-timestamp reference model; a 4-bit-counter copy shows saturation.
module tb_issue_scheduler;
  localparam int HD = 2;
  localparam int FS = 1;

  localparam logic [3:0] OP_NOP = 4'h0, OP_ST = 4'h3, OP_ADD = 4'h4, OP_INC = 4'h5,
                         OP_NEG = 4'h6, OP_SUB = 4'h7, OP_BRZ = 4'h9, OP_JM = 4'hA,
                         OP_BRN = 4'hB, OP_LD = 4'hE, OP_SVPC = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        instr_valid = 1'b0;
  logic        br_resolved = 1'b0;
  logic        br_taken = 1'b0;
  logic        stall, issue_valid;
  logic [31:0] issue_instr;
  logic [15:0] stall_count;
  logic [1:0]  dbg_state;
  logic        stall_s, issue_valid_s;
  logic [31:0] issue_instr_s;
  logic [3:0]  stall_count_s;
  logic [1:0]  dbg_state_s;

  issue_scheduler #(.HAZARD_DEPTH(HD), .FLUSH_SLOTS(FS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .br_resolved(br_resolved), .br_taken(br_taken), .stall(stall),
    .issue_instr(issue_instr), .issue_valid(issue_valid),
    .stall_count(stall_count), .dbg_state(dbg_state));

  issue_scheduler #(.HAZARD_DEPTH(HD), .FLUSH_SLOTS(FS), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .br_resolved(br_resolved), .br_taken(br_taken), .stall(stall_s),
    .issue_instr(issue_instr_s), .issue_valid(issue_valid_s),
    .stall_count(stall_count_s), .dbg_state(dbg_state_s));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input int rd, input int rs, input int rt);
    return {op, 6'(rd), 6'(rs), 6'(rt), 10'd0};
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // drive at negedge, sample combinational stall before the edge, return after edge+1
  task automatic cyc(input logic [31:0] w, input logic v, input logic br, input logic tk, output logic s);
    @(negedge clk);
    instr = w; instr_valid = v; br_resolved = br; br_taken = tk;
    #1 s = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; br_resolved = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: hazards from issue timestamps per register and for flags.
  int m_cycle, m_mode, m_flush, m_cnt, last_flag;
  int last_wr [64];

  task automatic model_reset();
    m_cycle = 0; m_mode = 0; m_flush = 0; m_cnt = 0; last_flag = -1000;
    for (int r = 0; r < 64; r++) last_wr[r] = -1000;
  endtask

  task automatic model_step(input logic [31:0] w, input logic v, input logic br, input logic tk,
                            output logic es, output logic ev, output logic [31:0] ei);
    logic r_rs, r_rt, r_fl, wr, fl, ctl, hz;
    int rd, rs, rt;
    rd = int'(w[27:22]); rs = int'(w[21:16]); rt = int'(w[15:10]);
    r_rs = 0; r_rt = 0; r_fl = 0; wr = 0; fl = 0; ctl = 0;
    case (w[31:28])
      OP_ADD, OP_SUB: begin r_rs = 1; r_rt = 1; wr = 1; fl = 1; end
      OP_INC, OP_NEG: begin r_rs = 1; wr = 1; fl = 1; end
      OP_LD:          begin r_rs = 1; wr = 1; end
      OP_SVPC:        wr = 1;
      OP_ST:          begin r_rs = 1; r_rt = 1; end
      OP_JM:          begin r_rs = 1; ctl = 1; end
      OP_BRZ, OP_BRN: begin r_rs = 1; r_fl = 1; ctl = 1; end
      default:        ;
    endcase
    hz = (r_rs && (m_cycle - last_wr[rs] <= HD)) || (r_rt && (m_cycle - last_wr[rt] <= HD)) ||
         (r_fl && (m_cycle - last_flag <= HD));
    es = 0; ev = 0; ei = 32'h0;
    if (m_mode == 0 || (m_mode == 1 && br && !tk)) begin
      m_mode = 0;
      if (v && hz) begin
        es = 1; m_cnt++;
      end else if (v) begin
        ev = 1; ei = w;
        if (wr) last_wr[rd] = m_cycle;
        if (fl) last_flag = m_cycle;
        if (ctl) m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (br && tk) begin m_mode = 2; m_flush = FS; end
      else es = 1;
    end else begin
      if (m_flush <= 1) m_mode = 0;
      m_flush--;
    end
    m_cycle++;
  endtask

  typedef struct {
    logic [31:0] w; logic v; logic br; logic tk;
    logic es; logic ev; logic [31:0] ei; int ec;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [31:0] w, input logic v, input logic br, input logic tk,
                     input logic es, input logic ev, input logic [31:0] ei, input int ec);
    vec_t r;
    r.w = w; r.v = v; r.br = br; r.tk = tk; r.es = es; r.ev = ev; r.ei = ei; r.ec = ec;
    vecs.push_back(r);
  endtask

  task automatic idle3(input int ec);
    for (int k = 0; k < 3; k++) add(32'h0, 0, 0, 0, 0, 0, 32'h0, ec);
  endtask

  initial begin
    logic s, es, ev, hold, cv, br, tk;
    logic [31:0] ei, cur, a1, jm, brn, ft, ft2, ft3, st, tw;

    // dependent pair: exactly two bubbles
    add(enc(OP_ADD,5,2,3), 1,0,0, 0,1, enc(OP_ADD,5,2,3), 0);
    add(enc(OP_ADD,4,4,5), 1,0,0, 1,0, 32'h0, 1);
    add(enc(OP_ADD,4,4,5), 1,0,0, 1,0, 32'h0, 2);
    add(enc(OP_ADD,4,4,5), 1,0,0, 0,1, enc(OP_ADD,4,4,5), 2);
    idle3(2);
    // independent back-to-back
    add(enc(OP_SUB,4,4,4), 1,0,0, 0,1, enc(OP_SUB,4,4,4), 2);
    add(enc(OP_ADD,5,2,3), 1,0,0, 0,1, enc(OP_ADD,5,2,3), 2);
    add(enc(OP_INC,2,2,0), 1,0,0, 0,1, enc(OP_INC,2,2,0), 2);
    idle3(2);
    // one independent instruction between: one bubble
    add(enc(OP_ADD,6,1,1), 1,0,0, 0,1, enc(OP_ADD,6,1,1), 2);
    add(enc(OP_INC,7,0,0), 1,0,0, 0,1, enc(OP_INC,7,0,0), 2);
    add(enc(OP_NEG,8,6,0), 1,0,0, 1,0, 32'h0, 3);
    add(enc(OP_NEG,8,6,0), 1,0,0, 0,1, enc(OP_NEG,8,6,0), 3);
    idle3(3);
    // SVPC/JM, taken; resolve pulse in the issuing cycle is ignored
    jm = enc(OP_JM,0,9,0); ft = enc(OP_ADD,13,14,15); tw = enc(OP_ADD,20,21,22);
    add(enc(OP_SVPC,9,0,0), 1,0,0, 0,1, enc(OP_SVPC,9,0,0), 3);
    add(jm, 1,0,0, 1,0, 32'h0, 4);
    add(jm, 1,0,0, 1,0, 32'h0, 5);
    add(jm, 1,1,1, 0,1, jm, 5);
    add(ft, 1,0,0, 1,0, 32'h0, 5);
    add(ft, 1,1,1, 0,0, 32'h0, 5);
    add(enc(OP_ADD,16,17,18), 1,0,0, 0,0, 32'h0, 5);
    add(tw, 1,0,0, 0,1, tw, 5);
    idle3(5);
    // SUB/BRN flag hazard, not taken
    brn = enc(OP_BRN,0,9,0); ft2 = enc(OP_ADD,10,11,12);
    add(enc(OP_SUB,8,2,5), 1,0,0, 0,1, enc(OP_SUB,8,2,5), 5);
    add(brn, 1,0,0, 1,0, 32'h0, 6);
    add(brn, 1,0,0, 1,0, 32'h0, 7);
    add(brn, 1,0,0, 0,1, brn, 7);
    add(ft2, 1,0,0, 1,0, 32'h0, 7);
    add(ft2, 1,1,0, 0,1, ft2, 7);
    idle3(7);
    // LD sets no flags: BRZ issues at once; resolve in first wait cycle
    ft3 = enc(OP_NEG,1,2,0);
    add(enc(OP_LD,30,1,0), 1,0,0, 0,1, enc(OP_LD,30,1,0), 7);
    add(enc(OP_BRZ,0,31,0), 1,0,0, 0,1, enc(OP_BRZ,0,31,0), 7);
    add(ft3, 1,1,0, 0,1, ft3, 7);
    idle3(7);
    // ST reads rt
    st = enc(OP_ST,0,0,3);
    add(enc(OP_INC,3,3,0), 1,0,0, 0,1, enc(OP_INC,3,3,0), 7);
    add(st, 1,0,0, 1,0, 32'h0, 8);
    add(st, 1,0,0, 1,0, 32'h0, 9);
    add(st, 1,0,0, 0,1, st, 9);

    // reset values
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", 0, issue_valid, 0);
    check("rst_instr", 0, issue_instr, 0);
    check("rst_stall", 0, stall, 0);
    check("rst_count", 0, stall_count, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      cyc(vecs[i].w, vecs[i].v, vecs[i].br, vecs[i].tk, s);
      check("tbl_stall", i, s, vecs[i].es);
      check("tbl_valid", i, issue_valid, vecs[i].ev);
      check("tbl_instr", i, issue_instr, vecs[i].ei);
      check("tbl_count", i, stall_count, vecs[i].ec);
      check("tbl_count_small", i, stall_count_s, sat(vecs[i].ec, 15));
    end

    // asynchronous reset while stalled
    do_reset();
    a1 = enc(OP_ADD,1,1,1);
    cyc(a1, 1,0,0, s); check("ms_stall0", 0, s, 0);
    cyc(a1, 1,0,0, s); check("ms_stall1", 1, s, 1);
    cyc(a1, 1,0,0, s); check("ms_stall2", 2, s, 1);
    cyc(a1, 1,0,0, s); check("ms_stall3", 3, s, 0);
    check("ms_valid_pre", 3, issue_valid, 1);
    check("ms_count_pre", 3, stall_count, 2);
    @(negedge clk);
    instr = a1; instr_valid = 1'b1;
    #1 check("ms_stall_pre", 4, stall, 1);
    rst = 1'b1;
    #1;
    check("ms_valid_rst", 4, issue_valid, 0);
    check("ms_instr_rst", 4, issue_instr, 0);
    check("ms_count_rst", 4, stall_count, 0);
    check("ms_stall_rst", 4, stall, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ms_stall_post", 5, stall, 0);
    @(posedge clk);
    #1;
    check("ms_valid_post", 5, issue_valid, 1);
    check("ms_instr_post", 5, issue_instr, a1);

    // random traffic against the model
    do_reset();
    model_reset();
    hold = 1'b0; cur = 32'h0; cv = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        cur = {4'($urandom_range(0,15)), 6'($urandom_range(0,3)), 6'($urandom_range(0,3)),
               6'($urandom_range(0,3)), 10'($urandom)};
        cv = ($urandom_range(0,7) != 0);
      end
      br = (m_mode == 1) ? ($urandom_range(0,2) == 0) : ($urandom_range(0,9) == 0);
      tk = 1'($urandom_range(0,1));
      model_step(cur, cv, br, tk, es, ev, ei);
      cyc(cur, cv, br, tk, s);
      check("rnd_stall", n, s, es);
      check("rnd_valid", n, issue_valid, ev);
      check("rnd_instr", n, issue_instr, ei);
      check("rnd_count", n, stall_count, sat(m_cnt, 65535));
      check("rnd_count_small", n, stall_count_s, sat(m_cnt, 15));
      hold = es;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Pipeline issue controller between the registered instruction memory and decode/execute. It detects register read-after-write and condition-flag hazards against recently issued instructions, stalls fetch, and inserts bubbles, so programs no longer need hand-placed NOP padding. It also holds issue across control-flow instructions until execute resolves them, and drops wrong-path fetches.

## Interface
Parameters:
- HAZARD_DEPTH, 2, number of issue slots after a producer before a dependent instruction may issue (1..4)
- FLUSH_SLOTS, 1, cycles of fetch output discarded after a taken branch or jump (1..3)
- CNT_W, 16, width of the stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- instr  in  32  instruction word from instruction memory
- instr_valid  in  1  instr is a fetched instruction
- br_resolved  in  1  one-cycle pulse from execute: the outstanding control instruction is resolved
- br_taken  in  1  qualified by br_resolved; 1 = PC redirected
- stall  out  1  combinational; 1 = fetch holds PC so instr is re-presented next cycle
- issue_instr  out  32  registered instruction to decode; 32'h0 (NOP) when bubble
- issue_valid  out  1  registered; issue_instr is a real instruction
- stall_count  out  CNT_W  data/flag-hazard stall cycles, saturating

## Operation
- Fields: op=instr[31:28], rd=[27:22], rs=[21:16], rt=[15:10].
- Writers of rd: ADD 0100, INC 0101, NEG 0110, SUB 0111, LD 1110, SVPC 1111. Flag setters: ADD, INC, NEG, SUB.
- Source reads: ADD/SUB use rs and rt. ST 0011 uses rs and rt. INC, NEG, LD, JM 1010, BRZ 1001 and BRN 1011 use rs. SVPC and NOP 0000 read nothing. BRZ and BRN also read flags.
- All 64 registers are treated identically, with no hardwired zero register.
- Scoreboard: a shift register of HAZARD_DEPTH entries {valid, writes, rd, sets_flags}. It shifts every cycle. Entry 0 receives the slot issued this edge; a bubble enters as valid=0.
- Hazard: the candidate instr reads a register equal to rd of any entry with valid=1 and writes=1, or the candidate is BRZ/BRN and any valid entry has sets_flags=1.
- State RUN:
  - If instr_valid=1 and there is a hazard: stall=1, issue a bubble, increment stall_count.
  - If instr_valid=1 and there is no hazard: stall=0, issue instr. If op is JM/BRZ/BRN, go to BR_WAIT.
  - If instr_valid=0: stall=0, issue a bubble.
- State BR_WAIT:
  - stall=1; the fall-through instr is held and bubbles are issued. stall_count does not increment.
  - On br_resolved with br_taken=0: go to RUN, with hazard evaluation in the same cycle.
  - On br_resolved with br_taken=1: go to FLUSH, load flush_cnt=FLUSH_SLOTS, stall=0.
- State FLUSH:
  - stall=0, issue bubbles, ignore instr and instr_valid.
  - flush_cnt decrements each cycle. At 1, go to RUN.
- br_resolved is ignored outside BR_WAIT.
- stall_count saturates at all-ones.

## Timing
- Reset values: issue_instr=0, issue_valid=0, stall=0, stall_count=0, state=RUN, all scoreboard entries invalid, flush_cnt=0.
- Reset asserted mid-operation clears all of these immediately, with no clock edge required.
- Issue latency: an instr accepted in cycle t appears on issue_instr/issue_valid after edge t+1.
- Dependency spacing: with HAZARD_DEPTH=2, a consumer issues no earlier than 3 edges after its producer, i.e. exactly 2 bubbles when they are back-to-back.
- A producer followed by one independent instruction needs only 1 bubble.
- stall is combinational from instr, instr_valid, state and scoreboard, and is valid in the same cycle.
- If br_resolved arrives in the same cycle BR_WAIT is entered (the edge that issues the branch), it is not seen. Execute pulses no earlier than the following cycle.

## Test plan
- Reset mid-stall: assert rst while stall=1 -> outputs return to reset values asynchronously; the first instruction after release issues without stall.
- ADD x5,x2,x3 then ADD x4,x4,x5 on consecutive cycles -> producer issued at edge 1, bubbles at edges 2-3, consumer at edge 4, stall_count=2.
- SUB x4,x4,x4; ADD x5,x2,x3; INC x2,x2,1 back-to-back (independent) -> three consecutive issues with issue_valid=1 and stall never 1.
- SVPC x9,1 then JM x9 -> 2 bubbles, JM issues, state BR_WAIT. br_resolved=1 with br_taken=1 -> 1 flush cycle (FLUSH_SLOTS=1); the held fall-through word is never issued.
- SUB x8,x2,x5 then BRN x9 -> 2 flag-hazard stalls. BRN issues. br_resolved with br_taken=0 -> fall-through issues on the next edge; stall_count=2.
- 65537 consecutive hazard stalls -> stall_count holds 16'hFFFF.
